mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback formatter for the RV32I 5-stage pipeline. It sits between the data-memory stage and the register file.
- Captures MEM-stage results each cycle.
- Selects and sign/zero-extends the writeback value.
- Drives the register file write port (data, address, write enable, instruction-valid) and the forwarding bus.
- Keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 104 ++++++++++
 tb/tb_mem_wb_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load formatting and writeback select.
// Drives the register file write port, forwarding qualifier and retire count.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int RET_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             VALID_IN,
  input  logic [4:0]       RD_IN,
  input  logic             REGWRITE_IN,
  input  logic [1:0]       WBSEL_IN,
  input  logic [2:0]       FUNCT3_IN,
  input  logic [XLEN-1:0]  ALU_RESULT_IN,
  input  logic [XLEN-1:0]  MEM_RDATA_IN,
  input  logic [XLEN-1:0]  PC4_IN,
  output logic [XLEN-1:0]  WB_DATA,
  output logic [4:0]       WB_ADDR,
  output logic             WB_WRITE,
  output logic             WB_VALID,
  output logic             FWD_VALID,
  output logic [RET_W-1:0] RET_COUNT
);

  logic [1:0]       off;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [XLEN-1:0]  load_v;
  logic [XLEN-1:0]  data_d, data_q;
  logic [4:0]       addr_q;
  logic             write_d, write_q;
  logic             valid_q;
  logic [RET_W-1:0] ret_q;

  assign off = ALU_RESULT_IN[1:0];

  always_comb begin
    byte_v = MEM_RDATA_IN[7:0];
    unique case (off)
      2'd0: byte_v = MEM_RDATA_IN[7:0];
      2'd1: byte_v = MEM_RDATA_IN[15:8];
      2'd2: byte_v = MEM_RDATA_IN[23:16];
      2'd3: byte_v = MEM_RDATA_IN[31:24];
    endcase
    half_v = off[1] ? MEM_RDATA_IN[31:16]
                    : MEM_RDATA_IN[15:0];
  end

  // Undefined funct3 codes fall back to a full word
  always_comb begin
    load_v = MEM_RDATA_IN;
    case (FUNCT3_IN)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b100:  load_v = {24'd0, byte_v};
      3'b101:  load_v = {16'd0, half_v};
      default: load_v = MEM_RDATA_IN;
    endcase
  end

  always_comb begin
    data_d = ALU_RESULT_IN;
    unique case (1'b1)
      (WBSEL_IN == 2'b01): data_d = load_v;
      (WBSEL_IN == 2'b10): data_d = PC4_IN;
      default:             data_d = ALU_RESULT_IN;
    endcase
  end

  assign write_d = VALID_IN & REGWRITE_IN
                 & (RD_IN != 5'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      ret_q   <= '0;
    end else if (FLUSH) begin
      data_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (!STALL) begin
      data_q  <= data_d;
      addr_q  <= RD_IN;
      write_q <= write_d;
      valid_q <= VALID_IN;
      if (VALID_IN)
        ret_q <= ret_q + {{(RET_W-1){1'b0}}, 1'b1};
    end
  end

  assign WB_DATA   = data_q;
  assign WB_ADDR   = addr_q;
  assign WB_WRITE  = write_q;
  assign WB_VALID  = valid_q;
  assign FWD_VALID = write_q;
  assign RET_COUNT = ret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver queues expected
// writeback state per cycle, monitor pops and compares after each edge.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH, VALID_IN, REGWRITE_IN;
  logic [4:0]  RD_IN;
  logic [1:0]  WBSEL_IN;
  logic [2:0]  FUNCT3_IN;
  logic [31:0] ALU_RESULT_IN, MEM_RDATA_IN, PC4_IN;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_ADDR;
  logic        WB_WRITE, WB_VALID, FWD_VALID;
  logic [3:0]  RET_COUNT;

  mem_wb_stage #(.XLEN(32), .RET_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .VALID_IN(VALID_IN), .RD_IN(RD_IN), .REGWRITE_IN(REGWRITE_IN),
    .WBSEL_IN(WBSEL_IN), .FUNCT3_IN(FUNCT3_IN),
    .ALU_RESULT_IN(ALU_RESULT_IN), .MEM_RDATA_IN(MEM_RDATA_IN),
    .PC4_IN(PC4_IN), .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR),
    .WB_WRITE(WB_WRITE), .WB_VALID(WB_VALID),
    .FWD_VALID(FWD_VALID), .RET_COUNT(RET_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wr;
    logic        vld;
    logic [3:0]  ret;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".data"}, WB_DATA, e.data);
      chk({e.tag, ".addr"}, {27'd0, WB_ADDR}, {27'd0, e.addr});
      chk({e.tag, ".wr"}, {31'd0, WB_WRITE}, {31'd0, e.wr});
      chk({e.tag, ".vld"}, {31'd0, WB_VALID}, {31'd0, e.vld});
      chk({e.tag, ".fwd"}, {31'd0, FWD_VALID}, {31'd0, e.wr});
      chk({e.tag, ".ret"}, {28'd0, RET_COUNT}, {28'd0, e.ret});
    end
  end

  task automatic step(
    input string       tag,
    input logic        rst, stl, fl, vin, rw,
    input logic [4:0]  rd,
    input logic [1:0]  sel,
    input logic [2:0]  f3,
    input logic [31:0] alu, mem, pc4,
    input logic [31:0] xdata
  );
    exp_t e;
    @(negedge CLK);
    RESET = rst; STALL = stl; FLUSH = fl;
    VALID_IN = vin; REGWRITE_IN = rw; RD_IN = rd;
    WBSEL_IN = sel; FUNCT3_IN = f3;
    ALU_RESULT_IN = alu; MEM_RDATA_IN = mem; PC4_IN = pc4;
    e = last;
    e.tag = tag;
    if (rst) begin
      e.data = 0; e.addr = 0; e.wr = 0; e.vld = 0; e.ret = 0;
    end else if (fl) begin
      e.data = 0; e.addr = 0; e.wr = 0; e.vld = 0;
    end else if (!stl) begin
      e.data = xdata;
      e.addr = rd;
      e.vld  = vin;
      e.wr   = vin && rw && (rd != 5'd0);
      e.ret  = last.ret + (vin ? 4'd1 : 4'd0);
    end
    last = e;
    q.push_back(e);
  endtask

  localparam logic [31:0] MW = 32'h80F0_7F81;

  initial begin
    RESET = 1; STALL = 0; FLUSH = 0; VALID_IN = 0; REGWRITE_IN = 0;
    RD_IN = 0; WBSEL_IN = 0; FUNCT3_IN = 0;
    ALU_RESULT_IN = 0; MEM_RDATA_IN = 0; PC4_IN = 0;
    last = '{32'd0, 5'd0, 1'b0, 1'b0, 4'd0, "init"};

    step("rst0", 1,0,0,1,1, 5, 2'b00, 3'b000, 32'h1234, 0, 0, 0);
    step("rst1", 1,0,0,1,1, 5, 2'b00, 3'b000, 32'h1234, 0, 0, 0);
    step("post", 0,0,0,1,1, 5, 2'b00, 3'b000, 32'h1234, 0, 0, 32'h1234);

    step("lb0",  0,0,0,1,1, 3, 2'b01, 3'b000, 0, MW, 0, 32'hFFFF_FF81);
    step("lbu0", 0,0,0,1,1, 3, 2'b01, 3'b100, 0, MW, 0, 32'h0000_0081);
    step("lb1",  0,0,0,1,1, 3, 2'b01, 3'b000, 1, MW, 0, 32'h0000_007F);
    step("lb3",  0,0,0,1,1, 3, 2'b01, 3'b000, 3, MW, 0, 32'hFFFF_FF80);
    step("lbu2", 0,0,0,1,1, 3, 2'b01, 3'b100, 2, MW, 0, 32'h0000_00F0);
    step("lh2",  0,0,0,1,1, 3, 2'b01, 3'b001, 2, MW, 0, 32'hFFFF_80F0);
    step("lhu2", 0,0,0,1,1, 3, 2'b01, 3'b101, 2, MW, 0, 32'h0000_80F0);
    step("lh3",  0,0,0,1,1, 3, 2'b01, 3'b001, 3, MW, 0, 32'hFFFF_80F0);
    step("lh0",  0,0,0,1,1, 3, 2'b01, 3'b001, 0, MW, 0, 32'h0000_7F81);
    step("lw",   0,0,0,1,1, 3, 2'b01, 3'b010, 2, MW, 0, MW);
    step("lw011",0,0,0,1,1, 3, 2'b01, 3'b011, 1, MW, 0, MW);

    step("sel00",0,0,0,1,1, 4, 2'b00, 3'b000, 32'h1234, MW, 32'h104, 32'h1234);
    step("sel10",0,0,0,1,1, 4, 2'b10, 3'b000, 32'h1234, MW, 32'h104, 32'h104);
    step("sel11",0,0,0,1,1, 4, 2'b11, 3'b000, 32'h1234, MW, 32'h104, 32'h1234);

    step("x0",   0,0,0,1,1, 0, 2'b00, 3'b000, 32'h77, 0, 0, 32'h77);
    step("bubl", 0,0,0,0,1, 9, 2'b00, 3'b000, 32'h55, 0, 0, 32'h55);
    step("nowr", 0,0,0,1,0, 9, 2'b00, 3'b000, 32'h66, 0, 0, 32'h66);

    step("ld7",  0,0,0,1,1, 7, 2'b00, 3'b000, 32'hAA, 0, 0, 32'hAA);
    step("stl1", 0,1,0,1,1, 12, 2'b10, 3'b000, 32'h11, 0, 32'h99, 0);
    step("stl2", 0,1,0,0,0, 13, 2'b00, 3'b000, 32'h22, 0, 0, 0);
    step("stl3", 0,1,0,1,1, 14, 2'b01, 3'b010, 32'h33, MW, 0, 0);
    step("flst", 0,1,1,1,1, 15, 2'b00, 3'b000, 32'h44, 0, 0, 0);
    step("fl",   0,0,1,1,1, 15, 2'b00, 3'b000, 32'h45, 0, 0, 0);
    step("afl",  0,0,0,1,1, 6, 2'b00, 3'b000, 32'h46, 0, 0, 32'h46);

    step("rstst",0,0,0,1,1, 6, 2'b00, 3'b000, 32'h47, 0, 0, 32'h47);
    step("rstst",1,1,0,1,1, 6, 2'b00, 3'b000, 32'h48, 0, 0, 0);
    step("rstfl",1,0,1,1,1, 6, 2'b00, 3'b000, 32'h48, 0, 0, 0);
    step("arst", 0,0,0,1,1, 8, 2'b00, 3'b000, 32'h49, 0, 0, 32'h49);

    for (int i = 0; i < 17; i++)
      step("wrap", 0,0,0,1,1, 5'(i + 1), 2'b00, 3'b000,
           32'h100 + i, 0, 0, 32'h100 + i);

    step("idle", 0,0,0,0,0, 0, 2'b00, 3'b000, 0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge CLK);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
